// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC result averaging block.
// Contents: channel width, 16.16 fraction width, timedata field offsets and
// the output FSM state encoding.
package tdc_pkg;

    localparam int CH_W      = 32;   // width of one 16.16 channel
    localparam int FRAC_BITS = 16;   // fractional bits of the 16.16 format
    localparam int CH_A_LSB  = 0;    // channel A occupies timedata[31:0]
    localparam int CH_B_LSB  = 32;   // channel B occupies timedata[63:32]

    typedef enum logic [0:0] {
        S_ACC  = 1'b0,               // output register empty
        S_FULL = 1'b1                // output register holds an unread average
    } avg_state_e;

endpackage

// File: rtl/tdc_avg_channel.sv
// One averaging channel: accumulator, shift-divide and range compare.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   clear        - discard the partial window
//   accept       - the current sample is accepted into the window
//   complete     - the accepted sample closes the window
//   sample       - unsigned 16.16 input value
//   in_range     - sample lies inside [WIN_MIN, WIN_MAX] (always 1 when
//                  TDC_AVG_OUTLIER_EN is not defined)
//   avg          - truncated average of accumulator plus current sample
// Optional feature macro: TDC_AVG_OUTLIER_EN.
module tdc_avg_channel
    import tdc_pkg::*;
#(
    parameter int              LOG2_N  = 4,
    parameter logic [CH_W-1:0] WIN_MIN = 32'h0000_0000,
    parameter logic [CH_W-1:0] WIN_MAX = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            accept,
    input  logic            complete,
    input  logic [CH_W-1:0] sample,
    output logic            in_range,
    output logic [CH_W-1:0] avg
);

    // Holds at most 2^LOG2_N - 1 samples before the completing one is added,
    // so 32+LOG2_N bits cannot overflow.
    localparam int ACC_W = CH_W + LOG2_N;

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] sum_s;

    // Running sum including the current sample, and its truncated average
    always_comb begin
        sum_s = acc_r + ACC_W'(sample);
        avg   = CH_W'(sum_s >> LOG2_N);
    end

`ifdef TDC_AVG_OUTLIER_EN
    // Inclusive window check on the incoming sample
    always_comb begin
        if ((sample >= WIN_MIN) && (sample <= WIN_MAX)) begin
            in_range = 1'b1;
        end else begin
            in_range = 1'b0;
        end
    end
`else
    logic unused_window_s;
    assign unused_window_s = ^{WIN_MIN, WIN_MAX};

    // Without outlier rejection every sample is considered valid
    always_comb begin
        in_range = 1'b1;
    end
`endif

    // Accumulator: cleared by reset/clear, restarted when a window completes
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clear) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (accept && complete) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (accept) begin
            acc_r <= sum_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/tdc_result_avg.sv
// Averages 2^LOG2_N accepted TDC samples per channel and presents the
// truncated averages on a valid/ready port.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   done, timedata      - sample strobe and 64-bit word (B in [63:32], A in [31:0])
//   clear               - discard the partial window
//   avg_valid/avg_ready - output handshake
//   avg_a, avg_b        - channel averages (16.16)
//   sample_cnt          - accepted samples in the current window
//   reject_cnt          - saturating count of rejected samples
//   overrun             - sticky flag, a completed window was dropped
// Optional feature macro: TDC_AVG_OUTLIER_EN (range-based sample rejection).
module tdc_result_avg
    import tdc_pkg::*;
#(
    parameter int              LOG2_N  = 4,
    parameter logic [CH_W-1:0] WIN_MIN = 32'h0000_0000,
    parameter logic [CH_W-1:0] WIN_MAX = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    input  logic [63:0]       timedata,
    input  logic              clear,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic [CH_W-1:0]   avg_a,
    output logic [CH_W-1:0]   avg_b,
    output logic [LOG2_N:0]   sample_cnt,
    output logic [15:0]       reject_cnt,
    output logic              overrun
);

    localparam int             CNT_W    = LOG2_N + 1;
    localparam logic [LOG2_N:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);

    logic              in_range_a_s;
    logic              in_range_b_s;
    logic [CH_W-1:0]   avg_a_s;
    logic [CH_W-1:0]   avg_b_s;
    logic              accept_s;
    logic              complete_s;

    logic [LOG2_N:0]   sample_cnt_r;
    avg_state_e        state_r;
    logic              avg_valid_r;
    logic [CH_W-1:0]   avg_a_r;
    logic [CH_W-1:0]   avg_b_r;
    logic              overrun_r;

    tdc_avg_channel #(
        .LOG2_N  (LOG2_N),
        .WIN_MIN (WIN_MIN),
        .WIN_MAX (WIN_MAX)
    ) u_chan_a (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .accept   (accept_s),
        .complete (complete_s),
        .sample   (timedata[CH_A_LSB +: CH_W]),
        .in_range (in_range_a_s),
        .avg      (avg_a_s)
    );

    tdc_avg_channel #(
        .LOG2_N  (LOG2_N),
        .WIN_MIN (WIN_MIN),
        .WIN_MAX (WIN_MAX)
    ) u_chan_b (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .accept   (accept_s),
        .complete (complete_s),
        .sample   (timedata[CH_B_LSB +: CH_W]),
        .in_range (in_range_b_s),
        .avg      (avg_b_s)
    );

    // clear beats a coincident done; a sample must pass on both channels
    assign accept_s   = done && !clear && in_range_a_s && in_range_b_s;
    assign complete_s = accept_s && (sample_cnt_r == LAST_CNT);

    // Accepted-sample counter for the current window
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            sample_cnt_r <= {CNT_W{1'b0}};
        end else if (complete_s) begin
            sample_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            sample_cnt_r <= sample_cnt_r + CNT_W'(1);
        end else begin
            sample_cnt_r <= sample_cnt_r;
        end
    end

`ifdef TDC_AVG_OUTLIER_EN
    logic        reject_s;
    logic [15:0] reject_cnt_r;

    // A discarded-by-clear sample is not a rejection
    assign reject_s = done && !clear && !(in_range_a_s && in_range_b_s);

    // Saturating count of out-of-range samples
    always_ff @(posedge clk) begin
        if (reset) begin
            reject_cnt_r <= 16'h0000;
        end else if (reject_s && (reject_cnt_r != 16'hFFFF)) begin
            reject_cnt_r <= reject_cnt_r + 16'h0001;
        end else begin
            reject_cnt_r <= reject_cnt_r;
        end
    end

    assign reject_cnt = reject_cnt_r;
`else
    assign reject_cnt = 16'h0000;
`endif

    // Output FSM: holds one result; a completion while full and unread drops
    // the new result and flags overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_ACC;
            avg_valid_r <= 1'b0;
            avg_a_r     <= {CH_W{1'b0}};
            avg_b_r     <= {CH_W{1'b0}};
            overrun_r   <= 1'b0;
        end else begin
            case (state_r)
                S_ACC: begin
                    if (complete_s) begin
                        state_r     <= S_FULL;
                        avg_valid_r <= 1'b1;
                        avg_a_r     <= avg_a_s;
                        avg_b_r     <= avg_b_s;
                    end else begin
                        state_r     <= S_ACC;
                        avg_valid_r <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (complete_s && avg_ready) begin
                        state_r     <= S_FULL;
                        avg_valid_r <= 1'b1;
                        avg_a_r     <= avg_a_s;
                        avg_b_r     <= avg_b_s;
                    end else if (complete_s) begin
                        state_r     <= S_FULL;
                        avg_valid_r <= 1'b1;
                        overrun_r   <= 1'b1;
                    end else if (avg_ready) begin
                        state_r     <= S_ACC;
                        avg_valid_r <= 1'b0;
                    end else begin
                        state_r     <= S_FULL;
                        avg_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= S_ACC;
                    avg_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign avg_valid  = avg_valid_r;
    assign avg_a      = avg_a_r;
    assign avg_b      = avg_b_r;
    assign sample_cnt = sample_cnt_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_tdc_result_avg.sv
// Scoreboard bench for tdc_result_avg (LOG2_N=2, WIN_MAX=32'h0010_0000).
// Expected averages are computed from the driven samples, queued at drive
// time and compared when the DUT hands a result over.
module tb_tdc_result_avg;

    localparam int          LOG2_N = 2;
    localparam logic [31:0] W_MIN  = 32'h0000_0000;
    localparam logic [31:0] W_MAX  = 32'h0010_0000;

    logic        clk;
    logic        reset;
    logic        done;
    logic [63:0] timedata;
    logic        clear;
    logic        avg_valid;
    logic        avg_ready;
    logic [31:0] avg_a;
    logic [31:0] avg_b;
    logic [2:0]  sample_cnt;
    logic [15:0] reject_cnt;
    logic        overrun;

    int vec_cnt = 0;
    int err_cnt = 0;

    // model state
    logic [63:0] sb_q[$];
    logic        push_pend = 1'b0;
    logic [63:0] push_val  = 64'h0;
    logic        flush_pend = 1'b0;
    int          m_cnt = 0;
    logic [33:0] m_sa = 34'h0;
    logic [33:0] m_sb = 34'h0;
    logic [15:0] m_rej = 16'h0;
    logic        m_ovr = 1'b0;

    tdc_result_avg #(
        .LOG2_N  (LOG2_N),
        .WIN_MIN (W_MIN),
        .WIN_MAX (W_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .done       (done),
        .timedata   (timedata),
        .clear      (clear),
        .avg_valid  (avg_valid),
        .avg_ready  (avg_ready),
        .avg_a      (avg_a),
        .avg_b      (avg_b),
        .sample_cnt (sample_cnt),
        .reject_cnt (reject_cnt),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: valid check, handshake pop/compare, then apply pushes
    always @(negedge clk) begin
        check_vec("avg_valid", {63'h0, avg_valid}, {63'h0, (sb_q.size() != 0)});
        if (avg_valid === 1'b1 && avg_ready === 1'b1 && sb_q.size() != 0) begin
            check_vec("avg_data", {avg_b, avg_a}, sb_q.pop_front());
        end
        if (push_pend) begin
            sb_q.push_back(push_val);
            push_pend = 1'b0;
        end
        if (flush_pend) begin
            sb_q.delete();
            flush_pend = 1'b0;
        end
    end

    // Drive one cycle of stimulus and advance the reference model
    task automatic step(input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic clr, input logic rdy);
        logic ok;
        done      = d;
        timedata  = {b, a};
        clear     = clr;
        avg_ready = rdy;
`ifdef TDC_AVG_OUTLIER_EN
        ok = (a >= W_MIN) && (a <= W_MAX) && (b >= W_MIN) && (b <= W_MAX);
`else
        ok = 1'b1;
`endif
        if (clr) begin
            m_cnt = 0;
            m_sa  = 34'h0;
            m_sb  = 34'h0;
        end else if (d && ok) begin
            m_sa = m_sa + {2'b00, a};
            m_sb = m_sb + {2'b00, b};
            m_cnt++;
            if (m_cnt == 4) begin
                if (sb_q.size() != 0 && !rdy) begin
                    m_ovr = 1'b1;
                end else begin
                    push_pend = 1'b1;
                    push_val  = {m_sb[33:2], m_sa[33:2]};
                end
                m_cnt = 0;
                m_sa  = 34'h0;
                m_sb  = 34'h0;
            end
        end else if (d) begin
            if (m_rej != 16'hFFFF) m_rej = m_rej + 16'h1;
        end
        @(posedge clk);
        #1;
        done  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        avg_ready  = 1'b0;
        flush_pend = 1'b1;
        push_pend  = 1'b0;
        m_cnt = 0;
        m_sa  = 34'h0;
        m_sb  = 34'h0;
        m_rej = 16'h0;
        m_ovr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check_vec({tag, "_cnt"}, {61'h0, sample_cnt}, 64'(m_cnt));
        check_vec({tag, "_rej"}, {48'h0, reject_cnt}, {48'h0, m_rej});
        check_vec({tag, "_ovr"}, {63'h0, overrun}, {63'h0, m_ovr});
    endtask

    initial begin
        logic [31:0] ra;
        logic        rd;
        logic        rr;
        logic        rc;
        int          guard;
        reset = 1'b1; done = 1'b0; timedata = 64'h0; clear = 1'b0; avg_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();
        check_vec("rst_valid", {63'h0, avg_valid}, 64'h0);
        check_vec("rst_avg", {avg_b, avg_a}, 64'h0);
        check_status("rst");

        // basic window, ready held high
        step(1'b1, 32'd1, 32'h0001_8000, 1'b0, 1'b1);
        step(1'b1, 32'd2, 32'h0001_8000, 1'b0, 1'b1);
        step(1'b1, 32'd3, 32'h0001_8000, 1'b0, 1'b1);
        check_vec("basic_cnt3", {61'h0, sample_cnt}, 64'd3);
        step(1'b1, 32'd6, 32'h0001_8000, 1'b0, 1'b1);
        check_vec("basic_valid", {63'h0, avg_valid}, 64'h1);
        check_vec("basic_avg", {avg_b, avg_a}, {32'h0001_8000, 32'd3});
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check_vec("basic_drop", {63'h0, avg_valid}, 64'h0);
        check_status("basic");

        // completion coincident with handshake while full
        for (int i = 0; i < 4; i++) step(1'b1, 32'd7, 32'd70, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'd20, 32'd40, 1'b0, 1'b0);
        step(1'b1, 32'd24, 32'd44, 1'b0, 1'b1);
        check_vec("same_valid", {63'h0, avg_valid}, 64'h1);
        check_vec("same_avg", {avg_b, avg_a}, {32'd41, 32'd21});
        check_status("same");
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        // overrun: two windows with ready low
        for (int i = 0; i < 4; i++) step(1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
        check_vec("ovr_flag", {63'h0, overrun}, 64'h1);
        check_vec("ovr_held", {avg_b, avg_a}, {32'd5, 32'd5});
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check_vec("ovr_empty", {63'h0, avg_valid}, 64'h0);
        check_status("ovr");

        // outlier on channel A
        step(1'b1, 32'h0020_0000, 32'd1, 1'b0, 1'b1);
        check_status("outl");
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

        // clear beats a coincident done
        for (int i = 0; i < 3; i++) step(1'b1, 32'd100, 32'd100, 1'b0, 1'b1);
        step(1'b1, 32'd100, 32'd100, 1'b1, 1'b1);
        check_vec("clr_cnt", {61'h0, sample_cnt}, 64'd0);
        check_status("clr");
        for (int i = 0; i < 4; i++) step(1'b1, 32'd8, 32'd8, 1'b0, 1'b1);
        check_vec("clr_avg", {avg_b, avg_a}, {32'd8, 32'd8});

        // reset mid-window with output pending
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'd4, 32'd4, 1'b0, 1'b0);
        step(1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
        step(1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
        check_vec("pre_rst_cnt", {61'h0, sample_cnt}, 64'd2);
        check_vec("pre_rst_valid", {63'h0, avg_valid}, 64'h1);
        do_reset();
        check_vec("mid_rst_valid", {63'h0, avg_valid}, 64'h0);
        check_vec("mid_rst_avg", {avg_b, avg_a}, 64'h0);
        check_status("mid_rst");
        for (int i = 0; i < 4; i++) step(1'b1, 32'd12, 32'd16, 1'b0, 1'b1);
        check_vec("post_rst_avg", {avg_b, avg_a}, {32'd16, 32'd12});

        // random back-to-back traffic with random ready and occasional clear
        for (int i = 0; i < 200; i++) begin
            rd = 1'($urandom_range(0, 3) != 0);
            rr = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 15) == 0);
            ra = ($urandom_range(0, 7) == 0) ? 32'h0030_0000 : 32'($urandom_range(0, 32'h000F_FFFF));
            step(rd, ra, 32'($urandom_range(0, 32'h000F_FFFF)), rc, rr);
        end
        check_status("rand");

        // drain any pending result within a bounded number of cycles
        guard = 0;
        while (sb_q.size() != 0 && guard < 10) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            guard++;
        end
        check_vec("drain", 64'(sb_q.size()), 64'h0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/tdc_result_avg.md
# tdc_result_avg

Downstream consumer of the TDC interface stage: captures each 64-bit `timedata` word on its `done` strobe and splits it into two 32-bit 16.16 fixed-point channels. It accumulates a window of 2^LOG2_N accepted samples per channel and presents the truncated averages on a valid/ready output port for the host/readout logic. Optional outlier rejection discards samples outside a fixed range.

## Interface
- `LOG2_N`, 4, log2 of samples per averaging window; legal 0..8.
- `WIN_MIN`, 32'h0000_0000, inclusive lower bound for a valid sample, applied to both channels.
- `WIN_MAX`, 32'hFFFF_FFFF, inclusive upper bound, applied to both channels.
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `done`  in  1  single-cycle strobe from the TDC stage; `timedata` is valid in this cycle.
- `timedata`  in  64  [31:0] channel A, [63:32] channel B, unsigned 16.16.
- `clear`  in  1  discard the partial window; restart the count.
- `avg_valid`  out  1  output register holds an unread average.
- `avg_ready`  in  1  consumer accepts when `avg_valid && avg_ready`.
- `avg_a`  out  32  channel A average.
- `avg_b`  out  32  channel B average.
- `sample_cnt`  out  LOG2_N+1  accepted samples in the current window.
- `reject_cnt`  out  16  rejected samples, saturating.
- `overrun`  out  1  sticky; set when a completed window is lost.

## Operation
- Reset values: `avg_valid`, `avg_a`, `avg_b`, `sample_cnt`, `reject_cnt` and `overrun` are 0; both accumulators are 0; FSM is in S_ACC.
- Sample acceptance: on `done`, the sample is accepted when both channels lie in [WIN_MIN, WIN_MAX] (macro on), or always (macro off).
- Accumulators are 32+LOG2_N bits wide and unsigned; overflow is impossible by construction.
- Window completion: the accepted sample that brings the count to 2^LOG2_N completes the window.
  - Average is (acc + sample) >> LOG2_N, truncated.
  - Accumulators and `sample_cnt` return to 0 in the same cycle.
  - LOG2_N=0: every accepted sample passes through unchanged.
- FSM:
  - S_ACC (output empty): window completion loads `avg_a`/`avg_b` and goes to S_FULL.
  - S_FULL (output held, `avg_valid`=1): handshake without completion goes to S_ACC. Completion with handshake in the same cycle loads the new result and stays in S_FULL. Completion without handshake keeps the old result, drops the new one, sets `overrun`, and stays in S_FULL.
- Output stability: `avg_a`/`avg_b` are stable while `avg_valid` is high.
- `clear`: zeroes the accumulators and `sample_cnt`. It beats a simultaneous `done`, whose sample is discarded and not counted as rejected. It does not affect a pending output or `overrun`. `clear` does not reset `overrun`; only `reset` clears it.
- Reset mid-window or with output pending: everything returns to reset values; the pending result is lost and no overrun is flagged.

## Timing
- Last accepted `done` in cycle k: `avg_valid` rises in k+1, with data valid at the same edge.
- Handshake in cycle k: `avg_valid` falls in k+1, unless a new window completed in cycle k.
- `sample_cnt` and `reject_cnt` update one cycle after `done`.
- Back-to-back `done` on consecutive cycles is supported; throughput is 1 sample/cycle.
- `avg_ready` may be held high permanently; `avg_valid` has no combinational dependence on `avg_ready`.

## Configuration
- `TDC_AVG_OUTLIER_EN` defined: window check active; rejected samples increment `reject_cnt`, saturating at 16'hFFFF.
- Not defined: no comparators; every `done` is accepted; `reject_cnt` is tied to 0. WIN_MIN and WIN_MAX are ignored.

## Structure
- Shared package `tdc_pkg`:
  - channel width constant (32) and 16.16 fraction-bits constant (16);
  - FSM state enum {S_ACC, S_FULL};
  - `timedata` field slice constants.
- One sub-module, `tdc_avg_channel`: accumulator, shift-divide and range compare for one channel. It is instantiated twice; the FSM, counters and handshake live in the top.

## Test plan
- LOG2_N=2; samples A=1,2,3,6 and B=4×32'h0001_8000; `avg_ready`=1 → `avg_valid` pulses 1 cycle after the 4th `done`, `avg_a`=3, `avg_b`=32'h0001_8000.
- `avg_ready`=0; two complete windows (A avg 5, then avg 9) → first result 5 is held, `overrun`=1; releasing `avg_ready` yields 5, then `avg_valid`=0.
- Completion in the same cycle as a handshake in S_FULL → new result loaded, `avg_valid` stays 1, `overrun`=0.
- Macro on, WIN_MAX=32'h0010_0000; A=32'h0020_0000 → `reject_cnt`=1, `sample_cnt` unchanged. Macro off, same stimulus → sample counted.
- 3 samples, then `clear` coincident with a 4th `done`, then 4 samples of 8 → `sample_cnt`=0 after the clear; next average is 8.
- `reset` asserted with `sample_cnt`=2 and `avg_valid`=1 → all outputs 0 in the next cycle; a following full window averages correctly.
